// File: rtl/pipelined_tree_multiplier.sv
// Pipelined WIDTH x WIDTH signed/unsigned multiplier: sign-magnitude capture, registered
// binary adder tree of partial products, registered sign correction, valid/ready + tag.
module pipelined_tree_multiplier #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_z,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int LEVELS = $clog2(WIDTH);
   localparam int STAGES = LEVELS + 1;
   localparam int PW     = 2 * WIDTH;

   logic                       adv;
   logic [STAGES:0]            vld_pipe_q;   // 0 = capture, k = tree level k, STAGES = output
   logic [LEVELS:0]            neg_q;
   logic [LEVELS:0][TAG_W-1:0] tag_q;
   logic [WIDTH-1:0]           maga_q, magb_q, maga_d, magb_d;
   logic                       neg_d;
   logic [PW-1:0]              out_z_q, out_z_d;
   logic [TAG_W-1:0]           out_tag_q;

   // Heap-ordered tree: node j sums nodes 2j and 2j+1; leaves WIDTH..2*WIDTH-1 are partial products.
   logic [PW-1:0]              node   [1:2*WIDTH-1];
   logic [PW-1:0]              tree_q [1:WIDTH-1];

   assign out_valid = vld_pipe_q[STAGES];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_z     = out_z_q;
   assign out_tag   = out_tag_q;

   always_comb begin
      neg_d  = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      maga_d = (in_signed && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
      magb_d = (in_signed && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;
   end

   always_comb begin
      for (int j = 1; j < WIDTH; j++) node[j] = tree_q[j];
      for (int i = 0; i < WIDTH; i++)
         node[WIDTH+i] = magb_q[i] ? (PW'(maga_q) << i) : '0;
   end

   // Negating a zero magnitude wraps back to zero, so no special case is needed.
   always_comb out_z_d = neg_q[LEVELS] ? (~tree_q[1] + PW'(1)) : tree_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         neg_q      <= '0;
         tag_q      <= '0;
         maga_q     <= '0;
         magb_q     <= '0;
         out_z_q    <= '0;
         out_tag_q  <= '0;
         for (int j = 1; j < WIDTH; j++) tree_q[j] <= '0;
      end else if (adv) begin
         vld_pipe_q         <= {vld_pipe_q[STAGES-1:0], in_valid};
         neg_q[LEVELS:1]    <= neg_q[LEVELS-1:0];
         tag_q[LEVELS:1]    <= tag_q[LEVELS-1:0];
         if (in_valid) begin
            neg_q[0] <= neg_d;
            tag_q[0] <= in_tag;
            maga_q   <= maga_d;
            magb_q   <= magb_d;
         end
         for (int j = 1; j < WIDTH; j++) tree_q[j] <= node[2*j] + node[2*j+1];
         out_z_q   <= out_z_d;
         out_tag_q <= tag_q[LEVELS];
      end
   end

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Bench for pipelined_tree_multiplier: WIDTH=32 and WIDTH=8 instances, queue scoreboard
// against an arithmetic reference product.
module tb_pipelined_tree_multiplier;
   logic clk, rst_n;

   logic        in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [31:0] in_a, in_b;
   logic [3:0]  in_tag, out_tag;
   logic [63:0] out_z;

   logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8;
   logic [7:0]  in_a8, in_b8;
   logic [3:0]  in_tag8, out_tag8;
   logic [15:0] out_z8;

   int n_assert, n_fail;
   logic [63:0] exp_z [$];
   logic [3:0]  exp_t [$];
   int negcnt, last_pop, run_len;
   logic hold;
   logic [63:0] hz;
   logic [3:0]  ht;

   pipelined_tree_multiplier #(.WIDTH(32), .TAG_W(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_tag(out_tag));

   pipelined_tree_multiplier #(.WIDTH(8), .TAG_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
      .in_signed(in_signed8), .in_tag(in_tag8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out_z(out_z8), .out_tag(out_tag8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: extend operands to 128 bits (sign- or zero-), multiply, keep 2*w bits.
   function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input int w);
      logic [127:0] one, ea, eb, lowmask;
      one     = 1;
      lowmask = (one << w) - one;
      ea = {64'b0, a};
      eb = {64'b0, b};
      if (s && a[w-1]) ea = ea | ~lowmask;
      if (s && b[w-1]) eb = eb | ~lowmask;
      return (ea * eb) & ((one << (2*w)) - one);
   endfunction

   // Scoreboard and output-stability monitor for the 32-bit instance.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_z", out_z, hz);
            chk("hold_tag", out_tag, ht);
         end
         hold = out_valid && !out_ready;
         hz   = out_z;
         ht   = out_tag;
         if (out_valid && out_ready) begin
            chk("sb_nonempty", exp_z.size() != 0, 1);
            if (exp_z.size() != 0) begin
               chk("sb_z", out_z, exp_z.pop_front());
               chk("sb_tag", out_tag, exp_t.pop_front());
            end
            run_len  = (negcnt == last_pop + 1) ? run_len + 1 : 1;
            last_pop = negcnt;
         end
      end
      negcnt++;
   end

   task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [3:0] t, input logic [63:0] z);
      int  guard;
      logic acc;
      guard = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
      do begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         guard++;
      end while (!acc && guard < 100);
      chk("accept", acc, 1);
      if (acc) begin
         exp_z.push_back(z);
         exp_t.push_back(t);
      end
      in_valid = 1'b0;
   endtask

   task automatic send32_rand(input logic [3:0] t);
      logic [31:0]  a, b;
      logic         s;
      logic [127:0] r;
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      r = ref_mul({32'b0, a}, {32'b0, b}, s, 32);
      send32(a, b, s, t, r[63:0]);
   endtask

   task automatic wait_out32(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_z.size() != 0 && g < 300) begin
         @(posedge clk);
         g++;
      end
      #1;
      chk("drain", exp_z.size(), 0);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] t, input logic [15:0] z);
      int cyc;
      in_valid8 = 1'b1; in_a8 = a; in_b8 = b; in_signed8 = s; in_tag8 = t;
      @(negedge clk);
      chk("ready8", in_ready8, 1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      cyc = 0;
      while (!out_valid8 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("lat8", cyc, 4);
      chk("z8", out_z8, z);
      chk("tag8", out_tag8, t);
   endtask

   initial begin
      int           cyc;
      logic [31:0]  da, db;
      logic [127:0] r;
      n_assert = 0; n_fail = 0;
      negcnt = 0; last_pop = -10; run_len = 0; hold = 1'b0;
      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b0;
      in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_signed8 = 1'b0; in_tag8 = '0; out_ready8 = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_z", out_z, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_valid8", out_valid8, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      out_ready = 1'b1;

      // -3 * 7 signed, latency
      send32(32'hFFFFFFFD, 32'd7, 1'b1, 4'd5, 64'hFFFFFFFFFFFFFFEB);
      wait_out32(cyc);
      chk("lat32", cyc, 6);
      chk("z_m3x7", out_z, 64'hFFFFFFFFFFFFFFEB);
      chk("tag_m3x7", out_tag, 5);
      drain();

      // Extremes
      send32(32'h80000000, 32'h80000000, 1'b1, 4'd1, 64'h4000000000000000);
      send32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd2, 64'hFFFFFFFE00000001);
      send32(32'hFFFFFFFB, 32'h00000000, 1'b1, 4'd3, 64'h0);
      drain();

      // Back-to-back random stream
      for (int i = 0; i < 20; i++) send32_rand(4'(i % 16));
      drain();
      chk("stream_run", run_len, 20);

      // Backpressure with a held offer
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send32_rand(4'(i + 7));
      wait_out32(cyc);
      chk("bp_valid", out_valid, 1);
      da = $urandom; db = $urandom;
      r  = ref_mul({32'b0, da}, {32'b0, db}, 1'b1, 32);
      in_valid = 1'b1; in_a = da; in_b = db; in_signed = 1'b1; in_tag = 4'hC;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", in_ready, 1);
      @(posedge clk); #1;
      exp_z.push_back(r[63:0]);
      exp_t.push_back(4'hC);
      in_valid = 1'b0;
      drain();
      repeat (5) @(posedge clk);

      // Reset with operations in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send32_rand(4'(i + 1));
      wait_out32(cyc);
      chk("inflight_valid", out_valid, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_z", out_z, 0);
      chk("mid_rst_tag", out_tag, 0);
      exp_z.delete();
      exp_t.delete();
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", in_ready, 1);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("no_stale", out_valid, 0);
      end
      @(posedge clk); #1;
      send32(32'd2, 32'd3, 1'b0, 4'd9, 64'd6);
      wait_out32(cyc);
      chk("z_2x3", out_z, 6);
      drain();

      // WIDTH=8 instance
      run8(8'h80, 8'h80, 1'b1, 4'hA, 16'h4000);
      run8(8'hFF, 8'hFF, 1'b0, 4'hB, 16'hFE01);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] a8, b8;
         logic       s8;
         a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom_range(0, 1));
         r  = ref_mul({56'b0, a8}, {56'b0, b8}, s8, 8);
         run8(a8, b8, s8, 4'(i), r[15:0]);
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
